// File: rtl/cluster_pkg.sv
// ============================================================================
// Module  : cluster_pkg
// Brief   : Shared constants and types for the 768-pad cluster unpacker.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cluster_pkg;

    localparam int MXPADS      = 768;
    localparam int MXADRBITS   = 11;
    localparam int MXCNTBITS   = 3;
    localparam int MXCLUSTBITS = 4;

    localparam int CLUSTER_WORD_BITS = MXADRBITS + MXCNTBITS;

    typedef struct packed {
        logic [MXADRBITS-1:0] adr;
        logic [MXCNTBITS-1:0] cnt;
    } cluster_word_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cluster_mask_gen.sv
// ============================================================================
// Module  : cluster_mask_gen
// Brief   : Combinational span mask for one cluster plus end-of-array overflow.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cluster_mask_gen #(
    parameter int MXPADS    = cluster_pkg::MXPADS,
    parameter int MXADRBITS = cluster_pkg::MXADRBITS,
    parameter int MXCNTBITS = cluster_pkg::MXCNTBITS
) (
    input  logic [MXADRBITS-1:0] adr,
    input  logic [MXCNTBITS-1:0] cnt,
    input  logic                 valid,
    output logic [MXPADS-1:0]    mask,
    output logic                 ovf
);
    localparam int               c_ewidth = MXADRBITS + 1;
    localparam logic [c_ewidth-1:0] c_npads = c_ewidth'(MXPADS);

    logic [c_ewidth-1:0] w_first;
    logic [c_ewidth-1:0] w_last;
    logic                w_ok;

    // One extra bit so adr+cnt past the address range cannot wrap.
    assign w_first = {1'b0, adr};
    assign w_last  = w_first + {{(c_ewidth-MXCNTBITS){1'b0}}, cnt};
    assign w_ok    = valid && (w_first < c_npads);
    assign ovf     = w_ok && (w_last >= c_npads);

    for (genvar i = 0; i < MXPADS; i++) begin : g_pad
        assign mask[i] = w_ok && (w_first <= c_ewidth'(i)) && (c_ewidth'(i) <= w_last);
    end

endmodule

`default_nettype wire

// File: rtl/cluster_unpacker768.sv
// ============================================================================
// Module  : cluster_unpacker768
// Brief   : Rebuilds per-pad hit bitmap and counts from a cluster stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cluster_unpacker768 #(
    parameter int MXPADS      = cluster_pkg::MXPADS,
    parameter int MXADRBITS   = cluster_pkg::MXADRBITS,
    parameter int MXCNTBITS   = cluster_pkg::MXCNTBITS,
    parameter int MXCLUSTBITS = cluster_pkg::MXCLUSTBITS
) (
    input  logic                          clock,
    input  logic                          global_reset_n,
    input  logic                          sof,
    input  logic                          eof,
    input  logic                          cluster_found,
    input  logic [MXADRBITS-1:0]          adr,
    input  logic [MXCNTBITS-1:0]          cnt,
    output logic [MXPADS-1:0]             vpfs_out,
    output logic [MXPADS*MXCNTBITS-1:0]   cnts_out,
    output logic                          frame_valid,
    output logic [MXCLUSTBITS-1:0]        nclusters,
    output logic                          adr_err,
    output logic                          ovf_err,
    output logic                          frame_err
);
    import cluster_pkg::*;

    localparam logic [MXCLUSTBITS-1:0] c_ncl_max = '1;
    localparam logic [MXADRBITS:0]     c_npads   = (MXADRBITS+1)'(MXPADS);

    state_t                        r_state, w_state_next;
    logic [MXPADS-1:0]             r_work_vpf, w_merged_vpf, w_mask;
    logic [MXPADS*MXCNTBITS-1:0]   r_work_cnts, w_merged_cnts;
    logic [MXCLUSTBITS-1:0]        r_work_ncl, w_merged_ncl;
    logic w_open, w_close, w_live, w_adr_ok, w_hit, w_ovf, w_clear_base, w_proto_err;

    assign w_open       = (r_state == ST_OPEN);
    assign w_close      = eof && w_open;
    assign w_live       = w_open || sof;
    assign w_adr_ok     = ({1'b0, adr} < c_npads);
    assign w_hit        = cluster_found && w_live && w_adr_ok;
    // On sof+eof the cycle's cluster goes to the closing frame, so keep the old base.
    assign w_clear_base = sof && !w_close;
    assign w_proto_err  = (eof && !w_open) || (sof && w_open && !eof);

    cluster_mask_gen #(
        .MXPADS    (MXPADS),
        .MXADRBITS (MXADRBITS),
        .MXCNTBITS (MXCNTBITS)
    ) u_mask_gen (
        .adr   (adr),
        .cnt   (cnt),
        .valid (w_hit),
        .mask  (w_mask),
        .ovf   (w_ovf)
    );

    always_comb begin
        w_state_next = r_state;
        if (sof) begin
            w_state_next = ST_OPEN;
        end else if (w_close) begin
            w_state_next = ST_IDLE;
        end
    end

    always_comb begin
        w_merged_vpf  = (w_clear_base ? '0 : r_work_vpf) | w_mask;
        w_merged_cnts = w_clear_base ? '0 : r_work_cnts;
        w_merged_ncl  = w_clear_base ? '0 : r_work_ncl;
        if (w_hit) begin
            for (int p = 0; p < MXPADS; p++) begin
                if (adr == MXADRBITS'(p)) begin
                    w_merged_cnts[p*MXCNTBITS +: MXCNTBITS] = cnt;
                end
            end
            if (w_merged_ncl != c_ncl_max) begin
                w_merged_ncl = w_merged_ncl + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_state     <= ST_IDLE;
            r_work_vpf  <= '0;
            r_work_cnts <= '0;
            r_work_ncl  <= '0;
            vpfs_out    <= '0;
            cnts_out    <= '0;
            nclusters   <= '0;
            frame_valid <= 1'b0;
            adr_err     <= 1'b0;
            ovf_err     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            frame_valid <= w_close;
            if (sof && w_close) begin
                r_work_vpf  <= '0;
                r_work_cnts <= '0;
                r_work_ncl  <= '0;
            end else if (w_live) begin
                r_work_vpf  <= w_merged_vpf;
                r_work_cnts <= w_merged_cnts;
                r_work_ncl  <= w_merged_ncl;
            end
            if (w_close) begin
                vpfs_out  <= w_merged_vpf;
                cnts_out  <= w_merged_cnts;
                nclusters <= w_merged_ncl;
            end
            if (cluster_found && w_live && !w_adr_ok) begin
                adr_err <= 1'b1;
            end
            if (w_ovf) begin
                ovf_err <= 1'b1;
            end
            if (w_proto_err) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cluster_unpacker768.sv
// ============================================================================
// Module  : tb_cluster_unpacker768
// Brief   : Scoreboard bench for cluster_unpacker768 with a behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cluster_unpacker768;

    logic          clock;
    logic          global_reset_n;
    logic          sof, eof, cluster_found;
    logic [10:0]   adr;
    logic [2:0]    cnt;
    logic [767:0]  vpfs_out;
    logic [2303:0] cnts_out;
    logic          frame_valid;
    logic [3:0]    nclusters;
    logic          adr_err, ovf_err, frame_err;

    cluster_unpacker768 dut (
        .clock          (clock),
        .global_reset_n (global_reset_n),
        .sof            (sof),
        .eof            (eof),
        .cluster_found  (cluster_found),
        .adr            (adr),
        .cnt            (cnt),
        .vpfs_out       (vpfs_out),
        .cnts_out       (cnts_out),
        .frame_valid    (frame_valid),
        .nclusters      (nclusters),
        .adr_err        (adr_err),
        .ovf_err        (ovf_err),
        .frame_err      (frame_err)
    );

    typedef struct {
        logic [767:0]  vpf;
        logic [2303:0] cnts;
        logic [3:0]    ncl;
    } frame_t;

    frame_t        sb_q[$];
    int            checks = 0;
    int            errors = 0;

    bit            m_open;
    logic [767:0]  m_vpf;
    logic [2303:0] m_cnts;
    int            m_ncl;
    bit            m_adr_err, m_ovf_err, m_frame_err;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Scoreboard: every frame_valid pulse must match the oldest expected frame.
    always @(negedge clock) begin
        if (global_reset_n && frame_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame_valid got 1 want 0");
            end else begin
                frame_t f;
                f = sb_q.pop_front();
                if (vpfs_out !== f.vpf) begin
                    errors++;
                    $display("FAIL vpfs_out got %h want %h", vpfs_out, f.vpf);
                end
                checks++;
                if (cnts_out !== f.cnts) begin
                    errors++;
                    for (int p = 0; p < 768; p++) begin
                        if (cnts_out[p*3 +: 3] !== f.cnts[p*3 +: 3]) begin
                            $display("FAIL cnts_out pad %0d got %0d want %0d",
                                     p, cnts_out[p*3 +: 3], f.cnts[p*3 +: 3]);
                            break;
                        end
                    end
                end
                checks++;
                if (nclusters !== f.ncl) begin
                    errors++;
                    $display("FAIL nclusters got %0d want %0d", nclusters, f.ncl);
                end
            end
        end
    end

    task automatic clear_work();
        m_vpf  = '0;
        m_cnts = '0;
        m_ncl  = 0;
    endtask

    task automatic model_reset();
        clear_work();
        m_open      = 0;
        m_adr_err   = 0;
        m_ovf_err   = 0;
        m_frame_err = 0;
        sb_q.delete();
    endtask

    // Drives one cycle (called at posedge+1) and advances the reference model.
    task automatic step(input bit s, input bit e, input bit cf, input int a, input int c);
        bit     close, live, hit;
        frame_t f;
        sof = s; eof = e; cluster_found = cf; adr = 11'(a); cnt = 3'(c);
        close = e && m_open;
        live  = m_open || s;
        hit   = cf && live && (a < 768);
        if (cf && live && a >= 768) m_adr_err = 1;
        if ((e && !m_open) || (s && m_open && !e)) m_frame_err = 1;
        if (s && !close) clear_work();
        if (hit) begin
            for (int p = a; p <= a + c; p++) begin
                if (p < 768) m_vpf[p] = 1'b1;
                else         m_ovf_err = 1;
            end
            m_cnts[a*3 +: 3] = 3'(c);
            if (m_ncl < 15) m_ncl++;
        end
        if (close) begin
            f.vpf  = m_vpf;
            f.cnts = m_cnts;
            f.ncl  = 4'(m_ncl);
            sb_q.push_back(f);
        end
        if (s && close) clear_work();
        if (s)          m_open = 1;
        else if (close) m_open = 0;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        checks++;
        if (vpfs_out !== '0 || cnts_out !== '0) begin
            errors++;
            $display("FAIL reset_bitmap got vpf_or=%b cnt_or=%b want 0", |vpfs_out, |cnts_out);
        end
        checks++;
        if (nclusters !== 4'd0 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ncl_fv got ncl=%0d fv=%b want 0 0", nclusters, frame_valid);
        end
        checks++;
        if ({adr_err, ovf_err, frame_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_errs got %b want 000", {adr_err, ovf_err, frame_err});
        end
    endtask

    task automatic test_basic();
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 100, 3);
        step(0, 1, 0, 0, 0);
        checks++;
        if (frame_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_fv got %b want 1", frame_valid);
        end
        checks++;
        if (vpfs_out[103:99] !== 5'b11110 || vpfs_out[0] !== 1'b1 || $countones(vpfs_out) != 5) begin
            errors++;
            $display("FAIL basic_bits got ones=%0d want 5", $countones(vpfs_out));
        end
        checks++;
        if (cnts_out[300 +: 3] !== 3'd3 || nclusters !== 4'd2) begin
            errors++;
            $display("FAIL basic_cnt got cnt100=%0d ncl=%0d want 3 2", cnts_out[300 +: 3], nclusters);
        end
        idle();
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse got %b want 0", frame_valid);
        end
    endtask

    task automatic test_overflow();
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 765, 7);
        step(0, 1, 0, 0, 0);
        checks++;
        if (vpfs_out[767:765] !== 3'b111 || $countones(vpfs_out) != 3 || nclusters !== 4'd1) begin
            errors++;
            $display("FAIL ovf_frame got ones=%0d ncl=%0d want 3 1", $countones(vpfs_out), nclusters);
        end
        checks++;
        if (ovf_err !== 1'b1 || adr_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_flag got ovf=%b adr=%b want 1 0", ovf_err, adr_err);
        end
        idle();
    endtask

    task automatic test_bad_adr();
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 800, 0);
        step(0, 1, 0, 0, 0);
        checks++;
        if (vpfs_out !== '0 || nclusters !== 4'd0 || adr_err !== 1'b1) begin
            errors++;
            $display("FAIL bad_adr got ones=%0d ncl=%0d adr_err=%b want 0 0 1",
                     $countones(vpfs_out), nclusters, adr_err);
        end
        idle();
    endtask

    task automatic test_saturation();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 1, i * 10, 1);
        step(0, 1, 0, 0, 0);
        checks++;
        if ($countones(vpfs_out) != 40 || nclusters !== 4'd15) begin
            errors++;
            $display("FAIL saturation got ones=%0d ncl=%0d want 40 15", $countones(vpfs_out), nclusters);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 50, 2);
        step(1, 1, 1, 60, 0);
        checks++;
        if (frame_valid !== 1'b1 || vpfs_out[52:50] !== 3'b111 || vpfs_out[60] !== 1'b1
            || $countones(vpfs_out) != 4) begin
            errors++;
            $display("FAIL b2b_first got fv=%b ones=%0d want 1 4", frame_valid, $countones(vpfs_out));
        end
        step(0, 0, 1, 70, 0);
        step(0, 1, 0, 0, 0);
        checks++;
        if (frame_valid !== 1'b1 || vpfs_out[70] !== 1'b1 || $countones(vpfs_out) != 1) begin
            errors++;
            $display("FAIL b2b_second got fv=%b ones=%0d want 1 1", frame_valid, $countones(vpfs_out));
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_frame_err got %b want 0", frame_err);
        end
        idle();
    endtask

    task automatic test_reset_midframe();
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 10, 1);
        step(0, 0, 1, 20, 2);
        step(0, 0, 1, 30, 3);
        #3;
        global_reset_n = 1'b0;
        #1;
        model_reset();
        test_reset();
        sof = 0; eof = 0; cluster_found = 0; adr = '0; cnt = '0;
        @(negedge clock);
        global_reset_n = 1'b1;
        @(posedge clock);
        #1;
        step(0, 1, 0, 0, 0);
        checks++;
        if (frame_err !== 1'b1 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL eof_idle got ferr=%b fv=%b want 1 0", frame_err, frame_valid);
        end
        checks++;
        if (vpfs_out !== '0 || nclusters !== 4'd0) begin
            errors++;
            $display("FAIL eof_idle_hold got ones=%0d ncl=%0d want 0 0", $countones(vpfs_out), nclusters);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 800), $urandom_range(0, 7));
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        checks++;
        if ({adr_err, ovf_err, frame_err} !== {m_adr_err, m_ovf_err, m_frame_err}) begin
            errors++;
            $display("FAIL random_errs got %b want %b", {adr_err, ovf_err, frame_err},
                     {m_adr_err, m_ovf_err, m_frame_err});
        end
    endtask

    initial begin
        global_reset_n = 1'b0;
        sof = 0; eof = 0; cluster_found = 0; adr = '0; cnt = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        @(negedge clock);
        global_reset_n = 1'b1;
        @(posedge clock);
        #1;
        test_basic();
        test_overflow();
        test_bad_adr();
        test_saturation();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        idle();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_frames got %0d pending want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
